// File: rtl/matrix_pkg.sv
// Shared constants, readout FSM states and the streamed entry format for the
// 12x12x36b result array readout path.
package matrix_pkg;
  localparam int ROWS   = 12;
  localparam int COLS   = 12;
  localparam int DATA_W = 36;
  localparam int AW     = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     row;
    logic [AW-1:0]     col;
    logic              last;
  } entry_t;
endpackage

// File: rtl/readout_fifo.sv
// Synchronous FIFO of readout entries; DEPTH must be a power of 2 so the
// pointers wrap naturally.
module readout_fifo
  import matrix_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so push on full is legal when paired with a pop
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/matrix_readout.sv
// Streams every entry of the result array out on a valid/ready port.
// MATRIX_READOUT_COLMAJOR_EN selects column-major walk order (default row-major).
module matrix_readout
  import matrix_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              arr_wr_active,
  output logic [AW-1:0]     arr_addr_row,
  output logic [AW-1:0]     arr_addr_col,
  output logic              arr_read_en,
  input  logic [DATA_W-1:0] arr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_row,
  output logic [AW-1:0]     out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e     state, nxt_state;
  logic [AW-1:0] row_cnt, col_cnt, row_d1, col_d1;
  logic          rd_d1, last_d1, is_last_addr, credit_ok, pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;
  logic          fifo_full, fifo_empty;
  entry_t        head, push_entry;

  assign is_last_addr = (row_cnt == AW'(ROWS-1)) && (col_cnt == AW'(COLS-1));
  // entries buffered plus the read whose data returns this cycle
  assign occ          = (CW+1)'(fifo_count) + (CW+1)'(rd_d1);
  assign credit_ok    = !fifo_full && (occ < (CW+1)'(FIFO_DEPTH));
  assign arr_addr_row = row_cnt;
  assign arr_addr_col = col_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start) nxt_state = ISSUE;
      ISSUE:   if (arr_read_en && is_last_addr) nxt_state = DRAIN;
      DRAIN:   if (pop && head.last) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    arr_read_en = (state == ISSUE) && !arr_wr_active && credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (arr_read_en) begin
`ifdef MATRIX_READOUT_COLMAJOR_EN
      if (row_cnt == AW'(ROWS-1)) begin
        row_cnt <= '0;
        col_cnt <= (col_cnt == AW'(COLS-1)) ? '0 : col_cnt + 1'b1;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
`else
      if (col_cnt == AW'(COLS-1)) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == AW'(ROWS-1)) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
`endif
    end
  end

  // tag travels alongside the 1-cycle array read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1   <= 1'b0;
      row_d1  <= '0;
      col_d1  <= '0;
      last_d1 <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_d1 <= arr_read_en;
      if (arr_read_en) begin
        row_d1  <= row_cnt;
        col_d1  <= col_cnt;
        last_d1 <= is_last_addr;
      end
      done <= (state == DRAIN) && pop && head.last;
    end
  end

  assign push_entry = '{data: arr_data, row: row_d1, col: col_d1, last: last_d1};
  assign pop        = out_valid && out_ready;

  readout_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_d1),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.data : '0;
  assign out_row   = out_valid ? head.row  : '0;
  assign out_col   = out_valid ? head.col  : '0;
  assign out_last  = out_valid && head.last;
endmodule
